serial_add_scheduler: RTL and testbench

SERIAL_ADD_SCHEDULER -- requirements
Module: serial_add_scheduler

---
 rtl/serial_add_scheduler_pkg.sv | 14 +
 rtl/serial_add_scheduler_if.sv | 41 ++++
 rtl/serial_add_scheduler_full_adder.sv | 27 ++
 rtl/serial_add_scheduler.sv | 97 +++++++++
 tb/tb_serial_add_scheduler.sv | 249 ++++++++++++++++++++++++
 5 files changed

// File: rtl/serial_add_scheduler_pkg.sv
// Shared definitions for the serial add scheduler.
//   WIDTH_DEFAULT : default operand width in bits
//   state_t       : scheduler FSM states
package serial_add_pkg;

   localparam int WIDTH_DEFAULT = 8;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_t;

endpackage

// File: rtl/serial_add_scheduler_if.sv
// Requester and response handshake bundle for the serial add scheduler.
//   req0_*/req1_* : valid/ready handshake plus operand pair per requester
//   rsp_*         : valid/ready handshake plus sum, carry and owning requester id
//   master        : requesters and result consumer side
//   slave         : scheduler side
interface serial_add_scheduler_if
   import serial_add_pkg::*;
#(
   parameter int WIDTH = WIDTH_DEFAULT
);
   logic             req0_valid;
   logic             req0_ready;
   logic [WIDTH-1:0] req0_a;
   logic [WIDTH-1:0] req0_b;
   logic             req1_valid;
   logic             req1_ready;
   logic [WIDTH-1:0] req1_a;
   logic [WIDTH-1:0] req1_b;
   logic             rsp_valid;
   logic             rsp_ready;
   logic [WIDTH-1:0] rsp_sum;
   logic             rsp_carry;
   logic             rsp_id;

   modport master (
      output req0_valid, req0_a, req0_b,
      output req1_valid, req1_a, req1_b,
      output rsp_ready,
      input  req0_ready, req1_ready,
      input  rsp_valid, rsp_sum, rsp_carry, rsp_id
   );

   modport slave (
      input  req0_valid, req0_a, req0_b,
      input  req1_valid, req1_a, req1_b,
      input  rsp_ready,
      output req0_ready, req1_ready,
      output rsp_valid, rsp_sum, rsp_carry, rsp_id
   );

endinterface

// File: rtl/serial_add_scheduler_full_adder.sv
// Single-bit adder shared by both requesters.
//   half_adder : a, b -> sum, carry
//   full_adder : a, b, cin -> sum, cout (two half adders, carries ORed)
module half_adder (
   input  logic a,
   input  logic b,
   output logic sum,
   output logic carry
);
   assign sum   = a ^ b;
   assign carry = a & b;
endmodule

module full_adder (
   input  logic a,
   input  logic b,
   input  logic cin,
   output logic sum,
   output logic cout
);
   logic s0, c0, c1;

   half_adder u_ha0 (.a(a),  .b(b),   .sum(s0),  .carry(c0));
   half_adder u_ha1 (.a(s0), .b(cin), .sum(sum), .carry(c1));

   assign cout = c0 | c1;
endmodule

// File: rtl/serial_add_scheduler.sv
// Bit-serial adder time-shared between two requesters with round-robin grant.
//   clk   : clock, rising edge
//   rst_n : asynchronous active-low reset
//   bus   : slave side of serial_add_scheduler_if (two requesters, one response)
//
// state | meaning
// IDLE  | waiting for a request; grant offered combinationally
// RUN   | adding one bit per cycle, LSB first, WIDTH cycles
// DONE  | result held on rsp_* until consumer takes it
module serial_add_scheduler
   import serial_add_pkg::*;
#(
   parameter int WIDTH = WIDTH_DEFAULT
)(
   input  logic                 clk,
   input  logic                 rst_n,
   serial_add_scheduler_if.slave bus
);
   localparam int            CW       = $clog2(WIDTH + 1);
   localparam logic [CW-1:0] LAST_BIT = CW'(WIDTH - 1);

   state_t           state_q, state_d;
   logic [WIDTH-1:0] a_q, b_q, sum_q;
   logic             carry_q;
   logic [CW-1:0]    cnt_q;
   logic             id_q;
   logic             last_q;
   logic             gnt_id;
   logic             accept;
   logic             fa_sum, fa_cout;

   // On a tie the requester not granted last wins; a lone requester always wins.
   always_comb begin
      gnt_id = bus.req1_valid;
      if (bus.req0_valid && bus.req1_valid) gnt_id = ~last_q;
   end

   // Gated by rst_n so ready stays low for the whole reset assertion.
   assign accept         = rst_n && (state_q == IDLE) && (bus.req0_valid || bus.req1_valid);
   assign bus.req0_ready = accept && !gnt_id;
   assign bus.req1_ready = accept && gnt_id;

   full_adder u_fa (
      .a    (a_q[0]),
      .b    (b_q[0]),
      .cin  (carry_q),
      .sum  (fa_sum),
      .cout (fa_cout)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state_q <= IDLE;
      else        state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE:    if (accept) state_d = RUN;
         RUN:     if (cnt_q == LAST_BIT) state_d = DONE;
         DONE:    if (bus.rsp_ready) state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         a_q     <= '0;
         b_q     <= '0;
         sum_q   <= '0;
         carry_q <= 1'b0;
         cnt_q   <= '0;
         id_q    <= 1'b0;
         last_q  <= 1'b1;
      end else if (accept) begin
         a_q     <= gnt_id ? bus.req1_a : bus.req0_a;
         b_q     <= gnt_id ? bus.req1_b : bus.req0_b;
         sum_q   <= '0;
         carry_q <= 1'b0;
         cnt_q   <= '0;
         id_q    <= gnt_id;
         last_q  <= gnt_id;
      end else if (state_q == RUN) begin
         a_q     <= a_q >> 1;
         b_q     <= b_q >> 1;
         sum_q   <= {fa_sum, sum_q[WIDTH-1:1]};
         carry_q <= fa_cout;
         cnt_q   <= cnt_q + CW'(1);
      end
   end

   assign bus.rsp_valid = (state_q == DONE);
   assign bus.rsp_sum   = bus.rsp_valid ? sum_q : '0;
   assign bus.rsp_carry = bus.rsp_valid && carry_q;
   assign bus.rsp_id    = bus.rsp_valid && id_q;

endmodule

// File: tb/tb_serial_add_scheduler.sv
module tb_serial_add_scheduler;
   localparam int W = 8;

   typedef struct {
      logic         id;
      logic [W-1:0] a;
      logic [W-1:0] b;
      logic [W-1:0] sum;
      logic         carry;
   } vec_t;

   typedef struct {
      logic         id;
      logic [W-1:0] sum;
      logic         carry;
   } exp_t;

   logic clk;
   logic rst_n;
   int   n_checks = 0;
   int   n_fail   = 0;
   exp_t sb[$];
   int   grant_q[$];
   logic prev_rdy0, prev_rdy1;
   vec_t tv[8];
   int   lat;
   bit   got;
   bit   done_flag;

   serial_add_scheduler_if #(.WIDTH(W)) bus ();

   serial_add_scheduler #(.WIDTH(W)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
      end
   endtask

   function automatic exp_t model(input logic id, input logic [W-1:0] a, input logic [W-1:0] b);
      exp_t e;
      logic [W:0] s;
      s       = {1'b0, a} + {1'b0, b};
      e.id    = id;
      e.sum   = s[W-1:0];
      e.carry = s[W];
      return e;
   endfunction

   // Scoreboard: push on each observed accept, pop and compare on each response handshake.
   always @(negedge clk) begin
      if (rst_n) begin
         check("rsp_zero_when_invalid",
               bus.rsp_valid ? 32'd0 : {23'd0, bus.rsp_id, bus.rsp_carry, bus.rsp_sum}, 32'd0);
         check("dual_ready", {31'd0, bus.req0_ready & bus.req1_ready}, 32'd0);
         check("ready_in_done", {31'd0, (bus.req0_ready | bus.req1_ready) & bus.rsp_valid}, 32'd0);
         check("ready0_one_cycle", {31'd0, bus.req0_ready & prev_rdy0}, 32'd0);
         check("ready1_one_cycle", {31'd0, bus.req1_ready & prev_rdy1}, 32'd0);
         if (bus.req0_ready) begin
            sb.push_back(model(1'b0, bus.req0_a, bus.req0_b));
            grant_q.push_back(0);
         end
         if (bus.req1_ready) begin
            sb.push_back(model(1'b1, bus.req1_a, bus.req1_b));
            grant_q.push_back(1);
         end
         if (bus.rsp_valid && bus.rsp_ready) begin
            if (sb.size() == 0) begin
               n_checks++;
               n_fail++;
               $display("FAIL unexpected_rsp: got sum 0x%0h id %0d with no pending request",
                        bus.rsp_sum, bus.rsp_id);
            end else begin
               exp_t e;
               e = sb.pop_front();
               check("sb_sum",   {24'd0, bus.rsp_sum},   {24'd0, e.sum});
               check("sb_carry", {31'd0, bus.rsp_carry}, {31'd0, e.carry});
               check("sb_id",    {31'd0, bus.rsp_id},    {31'd0, e.id});
            end
         end
         prev_rdy0 <= bus.req0_ready;
         prev_rdy1 <= bus.req1_ready;
      end else begin
         prev_rdy0 <= 1'b0;
         prev_rdy1 <= 1'b0;
      end
   end

   // Called just after a rising edge; returns just after the accept edge.
   task automatic send(input logic id, input logic [W-1:0] a, input logic [W-1:0] b,
                       input bit keep, output bit ok);
      ok = 1'b0;
      if (id) begin
         bus.req1_valid = 1'b1; bus.req1_a = a; bus.req1_b = b;
      end else begin
         bus.req0_valid = 1'b1; bus.req0_a = a; bus.req0_b = b;
      end
      for (int n = 0; n < 40 && !ok; n++) begin
         @(negedge clk);
         if (id ? bus.req1_ready : bus.req0_ready) ok = 1'b1;
         @(posedge clk);
         #1;
      end
      if (!keep) begin
         if (id) begin
            bus.req1_valid = 1'b0; bus.req1_a = 8'hAA; bus.req1_b = 8'h55;
         end else begin
            bus.req0_valid = 1'b0; bus.req0_a = 8'hAA; bus.req0_b = 8'h55;
         end
      end
   endtask

   task automatic wait_rsp(output int l);
      l = -1;
      for (int c = 1; c <= 40 && l < 0; c++) begin
         @(posedge clk);
         #1;
         if (bus.rsp_valid) l = c;
      end
   endtask

   task automatic wait_drain(input string name);
      bit ok;
      ok = 1'b0;
      for (int c = 0; c < 60 && !ok; c++) begin
         @(posedge clk);
         #1;
         if (sb.size() == 0 && !bus.rsp_valid) ok = 1'b1;
      end
      check(name, {31'd0, ok}, 32'd1);
   endtask

   initial begin
      tv[0] = '{1'b0, 8'h3C, 8'h05, 8'h41, 1'b0};
      tv[1] = '{1'b1, 8'hFF, 8'h01, 8'h00, 1'b1};
      tv[2] = '{1'b0, 8'h10, 8'h20, 8'h30, 1'b0};
      tv[3] = '{1'b1, 8'h80, 8'h80, 8'h00, 1'b1};
      tv[4] = '{1'b0, 8'h00, 8'h00, 8'h00, 1'b0};
      tv[5] = '{1'b1, 8'hA5, 8'h5A, 8'hFF, 1'b0};
      tv[6] = '{1'b0, 8'hFF, 8'hFF, 8'hFE, 1'b1};
      tv[7] = '{1'b0, 8'h01, 8'h7F, 8'h80, 1'b0};

      // Reset with both requesters already valid.
      rst_n          = 1'b0;
      bus.rsp_ready  = 1'b1;
      bus.req0_valid = 1'b1; bus.req0_a = 8'h11; bus.req0_b = 8'h22;
      bus.req1_valid = 1'b1; bus.req1_a = 8'hF0; bus.req1_b = 8'h23;
      #1;
      check("reset_rsp_valid", {31'd0, bus.rsp_valid}, 32'd0);
      check("reset_rsp_sum",   {24'd0, bus.rsp_sum},   32'd0);
      check("reset_ready0",    {31'd0, bus.req0_ready}, 32'd0);
      check("reset_ready1",    {31'd0, bus.req1_ready}, 32'd0);
      repeat (3) @(posedge clk);
      #1 rst_n = 1'b1;

      // Continuous tie: grants alternate starting with requester 0.
      done_flag = 1'b0;
      for (int c = 0; c < 100 && !done_flag; c++) begin
         @(posedge clk);
         #1;
         if (grant_q.size() >= 4) done_flag = 1'b1;
      end
      bus.req0_valid = 1'b0;
      bus.req1_valid = 1'b0;
      check("rr_four_grants", {31'd0, done_flag}, 32'd1);
      for (int i = 0; i < 4; i++)
         check($sformatf("rr_grant%0d", i), (i < grant_q.size()) ? grant_q[i] : 32'hFF, i % 2);
      wait_drain("rr_drain");

      // Table of single requests, each followed by a latency and result check.
      for (int i = 0; i < 8; i++) begin
         send(tv[i].id, tv[i].a, tv[i].b, 1'b0, got);
         check($sformatf("vec%0d_accept", i), {31'd0, got}, 32'd1);
         wait_rsp(lat);
         check($sformatf("vec%0d_latency", i), lat, W);
         check($sformatf("vec%0d_sum", i),   {24'd0, bus.rsp_sum},   {24'd0, tv[i].sum});
         check($sformatf("vec%0d_carry", i), {31'd0, bus.rsp_carry}, {31'd0, tv[i].carry});
         check($sformatf("vec%0d_id", i),    {31'd0, bus.rsp_id},    {31'd0, tv[i].id});
      end
      wait_drain("table_drain");

      // Consumer stalls 5 cycles in DONE while requester 0 waits.
      bus.rsp_ready = 1'b0;
      send(1'b1, 8'h9A, 8'h7C, 1'b0, got);
      check("stall_accept", {31'd0, got}, 32'd1);
      wait_rsp(lat);
      check("stall_latency", lat, W);
      bus.req0_valid = 1'b1; bus.req0_a = 8'h21; bus.req0_b = 8'h12;
      repeat (5) begin
         @(negedge clk);
         check("stall_valid", {31'd0, bus.rsp_valid}, 32'd1);
         check("stall_sum",   {24'd0, bus.rsp_sum},   32'h16);
         check("stall_carry", {31'd0, bus.rsp_carry}, 32'd1);
         check("stall_id",    {31'd0, bus.rsp_id},    32'd1);
         check("stall_no_ready0", {31'd0, bus.req0_ready}, 32'd0);
      end
      @(posedge clk);
      #1 bus.rsp_ready = 1'b1;
      @(negedge clk);
      check("stall_ready0_before_rsp_edge", {31'd0, bus.req0_ready}, 32'd0);
      @(negedge clk);
      check("stall_ready0_after_rsp_edge", {31'd0, bus.req0_ready}, 32'd1);
      @(posedge clk);
      #1 bus.req0_valid = 1'b0;
      wait_drain("stall_drain");

      // Reset in the middle of RUN discards the operation and restores the pointer.
      send(1'b0, 8'h33, 8'h44, 1'b1, got);
      check("rst_accept", {31'd0, got}, 32'd1);
      bus.req1_valid = 1'b1; bus.req1_a = 8'h05; bus.req1_b = 8'h06;
      repeat (3) @(posedge clk);
      #2 rst_n = 1'b0;
      #1;
      check("rst_rsp_valid", {31'd0, bus.rsp_valid}, 32'd0);
      check("rst_ready0",    {31'd0, bus.req0_ready}, 32'd0);
      check("rst_ready1",    {31'd0, bus.req1_ready}, 32'd0);
      sb.delete();
      grant_q.delete();
      bus.req0_a = 8'h01; bus.req0_b = 8'h02;
      repeat (2) @(posedge clk);
      #1 rst_n = 1'b1;
      done_flag = 1'b0;
      for (int c = 0; c < 20 && !done_flag; c++) begin
         @(posedge clk);
         #1;
         if (grant_q.size() >= 1) done_flag = 1'b1;
      end
      bus.req0_valid = 1'b0;
      bus.req1_valid = 1'b0;
      check("rst_regrant", {31'd0, done_flag}, 32'd1);
      check("rst_tie_grant0", (grant_q.size() > 0) ? grant_q[0] : 32'hFF, 32'd0);
      wait_drain("rst_drain");
      repeat (12) @(posedge clk);
      check("final_sb_empty", sb.size(), 32'd0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
